// File: rtl/rr_arbiter_16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_16_pkg
// Purpose  : Shared sizes and FSM state encodings for the 16-way arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package rr_arbiter_16_pkg;

    localparam int N_REQ = 16;
    localparam int ID_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/decoder_4_16.sv
`default_nettype none
// ============================================================================
// Module   : decoder_4_16
// Purpose  : 4-to-16 one-hot decoder with enable; {a,b,c,d} is the index.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_4_16 (
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        en,
    output logic [15:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[{a, b, c, d}] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_pick_16.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick_16
// Purpose  : Combinational rotating-priority search starting at ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick_16
    import rr_arbiter_16_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             any,
    output logic [ID_W-1:0]  idx
);

    logic [N_REQ-1:0] w_rot;
    logic [ID_W-1:0]  w_off;

    // w_rot[k] is the request k positions after ptr; the 4-bit add wraps mod 16.
    always_comb begin
        w_rot = '0;
        w_off = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_rot[i] = req[ID_W'(i) + ptr];
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = ID_W'(i);
            end
        end
    end

    assign any = |req;
    assign idx = ptr + w_off;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_16.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_16
// Purpose  : 16-way round-robin arbiter with hold limit and one-hot grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_16
    import rr_arbiter_16_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [ID_W-1:0] C_HOLD_LAST = ID_W'(MAX_HOLD - 1);

    state_t          r_state;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] r_hold_cnt;
    logic [ID_W-1:0] r_gnt_id;
    logic            r_gnt_valid;
    logic            r_timeout;

    logic            w_any;
    logic [ID_W-1:0] w_idx;
    logic            w_holder_req;
    logic            w_hold_hit;
    logic            w_end;

    rr_pick_16 u_pick (
        .req (req),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    assign w_holder_req = req[r_gnt_id];
    assign w_hold_hit   = (r_hold_cnt == C_HOLD_LAST);
    assign w_end        = done | ~w_holder_req | w_hold_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RELEASE: begin
                    r_timeout <= 1'b0;
                    if (w_any) begin
                        r_state     <= ST_GRANT;
                        r_gnt_id    <= w_idx;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= '0;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_gnt_valid <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (w_end) begin
                        r_state     <= ST_RELEASE;
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= r_gnt_id + 1'b1;
                        r_hold_cnt  <= '0;
                        // Only a pure hold-limit revocation counts as a timeout.
                        r_timeout   <= ~done & w_holder_req;
                    end else begin
                        r_hold_cnt  <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_gnt_valid <= 1'b0;
                    r_timeout   <= 1'b0;
                end
            endcase
        end
    end

    // Grant decode is combinational from registered state, so async reset clears gnt at once.
    decoder_4_16 u_dec (
        .a  (r_gnt_id[3]),
        .b  (r_gnt_id[2]),
        .c  (r_gnt_id[1]),
        .d  (r_gnt_id[0]),
        .en (r_gnt_valid),
        .y  (gnt)
    );

    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_16
// Purpose  : Self-checking bench for rr_arbiter_16 (MAX_HOLD = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_16;

    localparam int TB_MAX_HOLD = 4;
    localparam int N_TBL       = 27;
    localparam int N_RAND      = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_valid;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arbiter_16 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] req;
        logic        done;
        logic [15:0] gnt;
        logic        to;
    } vec_t;

    vec_t tbl [N_TBL];

    // Reference model: who holds the resource, for how long, and where the search starts.
    bit m_valid;
    bit m_to;
    int m_id;
    int m_ptr;
    int m_held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [15:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        done  = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m_valid = 0; m_to = 0; m_id = 0; m_ptr = 0; m_held = 0;
    endtask

    function automatic int pick(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [15:0] r, input logic d);
        int w;
        if (m_valid) begin
            if (d || !r[m_id] || m_held == TB_MAX_HOLD) begin
                m_valid = 0;
                m_to    = !d && r[m_id];
                m_ptr   = (m_id + 1) % 16;
            end else begin
                m_held++;
                m_to = 0;
            end
        end else begin
            m_to = 0;
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_valid = 1;
                m_id    = w;
                m_held  = 1;
            end
        end
    endtask

    function automatic vec_t mk(input logic [15:0] r, input logic d, input logic [15:0] g, input logic t);
        vec_t v;
        v.req = r; v.done = d; v.gnt = g; v.to = t;
        return v;
    endfunction

    initial begin
        logic [15:0] rr;
        logic        dd;
        logic [15:0] eg;

        // Wrap-around fairness from ptr=0: done in each grant's first cycle.
        tbl[0]  = mk(16'h8001, 1'b0, 16'h0001, 1'b0);
        tbl[1]  = mk(16'h8001, 1'b1, 16'h0000, 1'b0);
        tbl[2]  = mk(16'h8001, 1'b0, 16'h8000, 1'b0);
        tbl[3]  = mk(16'h8001, 1'b1, 16'h0000, 1'b0);
        tbl[4]  = mk(16'h8001, 1'b0, 16'h0001, 1'b0);
        tbl[5]  = mk(16'h8001, 1'b1, 16'h0000, 1'b0);
        tbl[6]  = mk(16'h8001, 1'b0, 16'h8000, 1'b0);
        tbl[7]  = mk(16'h0000, 1'b1, 16'h0000, 1'b0);
        tbl[8]  = mk(16'h0000, 1'b0, 16'h0000, 1'b0);
        // Single requester 5 with done in its third grant cycle, then regrant.
        tbl[9]  = mk(16'h0020, 1'b0, 16'h0020, 1'b0);
        tbl[10] = mk(16'h0020, 1'b0, 16'h0020, 1'b0);
        tbl[11] = mk(16'h0020, 1'b0, 16'h0020, 1'b0);
        tbl[12] = mk(16'h0020, 1'b1, 16'h0000, 1'b0);
        tbl[13] = mk(16'h0020, 1'b0, 16'h0020, 1'b0);
        tbl[14] = mk(16'h0000, 1'b0, 16'h0000, 1'b0);
        tbl[15] = mk(16'h0000, 1'b0, 16'h0000, 1'b0);
        // Hold limit of 4: timeout pulse, regrant, then done coinciding with the limit.
        tbl[16] = mk(16'h0008, 1'b0, 16'h0008, 1'b0);
        tbl[17] = mk(16'h0008, 1'b0, 16'h0008, 1'b0);
        tbl[18] = mk(16'h0008, 1'b0, 16'h0008, 1'b0);
        tbl[19] = mk(16'h0008, 1'b0, 16'h0008, 1'b0);
        tbl[20] = mk(16'h0008, 1'b0, 16'h0000, 1'b1);
        tbl[21] = mk(16'h0008, 1'b0, 16'h0008, 1'b0);
        tbl[22] = mk(16'h0008, 1'b0, 16'h0008, 1'b0);
        tbl[23] = mk(16'h0008, 1'b0, 16'h0008, 1'b0);
        tbl[24] = mk(16'h0008, 1'b0, 16'h0008, 1'b0);
        tbl[25] = mk(16'h0008, 1'b1, 16'h0000, 1'b0);
        tbl[26] = mk(16'h0000, 1'b0, 16'h0000, 1'b0);

        // Reset held with every requester active.
        reset = 1'b1;
        req   = 16'hFFFF;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_valid", 32'(gnt_valid), 32'h0);
        chk("reset_timeout", 32'(timeout), 32'h0);
        chk("reset_id", 32'(gnt_id), 32'h0);
        reset = 1'b0;
        cyc(16'hFFFF, 1'b0);
        chk("first_gnt", 32'(gnt), 32'h0001);
        chk("first_id", 32'(gnt_id), 32'h0);
        chk("first_valid", 32'(gnt_valid), 32'h1);

        do_reset();
        for (int i = 0; i < N_TBL; i++) begin
            cyc(tbl[i].req, tbl[i].done);
            chk($sformatf("tbl[%0d].gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl[%0d].valid", i), 32'(gnt_valid), 32'(tbl[i].gnt != 16'h0));
            chk($sformatf("tbl[%0d].timeout", i), 32'(timeout), 32'(tbl[i].to));
        end

        // Asynchronous reset in the middle of a grant.
        do_reset();
        cyc(16'h0400, 1'b0);
        chk("mid_pre_gnt", 32'(gnt), 32'h0400);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_async_gnt", 32'(gnt), 32'h0);
        chk("mid_async_timeout", 32'(timeout), 32'h0);
        req = 16'h0401;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_after_gnt", 32'(gnt), 32'h0001);
        chk("mid_after_id", 32'(gnt_id), 32'h0);

        // Randomized traffic against the reference model.
        do_reset();
        rr = '0;
        for (int n = 0; n < N_RAND; n++) begin
            case ($urandom_range(0, 3))
                0:       rr = '0;
                1:       rr = 16'(1) << $urandom_range(0, 15);
                2:       rr = 16'($urandom);
                default: rr = rr ^ (16'(1) << $urandom_range(0, 15));
            endcase
            dd = ($urandom_range(0, 3) == 0);
            model_step(rr, dd);
            cyc(rr, dd);
            eg = m_valid ? (16'(1) << m_id) : 16'h0;
            chk($sformatf("rand[%0d].gnt", n), 32'(gnt), 32'(eg));
            chk($sformatf("rand[%0d].timeout", n), 32'(timeout), 32'(m_to));
            if (m_valid) begin
                chk($sformatf("rand[%0d].id", n), 32'(gnt_id), 32'(m_id));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
Round-robin arbiter that shares one resource among 16 requesters and issues a one-hot grant.
- Priority pointer rotates past each winner, so no requester starves.
- The 4-bit grant index is registered; an existing decoder_4_16 instance decodes it to the one-hot grant vector, with gnt_valid as its enable.
- Grant ends on release, on withdrawal of the request, or on a hold timeout.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles a grant may be held; legal range 1..16; counter width is 4 bits.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req  input  16  request vector; bit i = requester i wants the resource.
done  input  1  holder releases the resource; sampled only in GRANT.
gnt  output  16  one-hot grant, decoded from gnt_id gated by gnt_valid; all zero when gnt_valid=0.
gnt_id  output  4  index of current holder; registered.
gnt_valid  output  1  a grant is active; registered.
timeout  output  1  one-cycle pulse: grant revoked by hold limit; registered.

Behaviour:
Reset (asynchronous, immediate):
- state=IDLE, ptr=0, hold_cnt=0, gnt_id=0, gnt_valid=0, timeout=0, so gnt=0.
- Reset mid-grant drops gnt within the same cycle, with no timeout pulse.

States: IDLE, GRANT, RELEASE.

Arbitration (evaluated in IDLE and RELEASE):
- Winner = first set bit of req, searching ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
- If req != 0, next edge: state=GRANT, gnt_id=winner, gnt_valid=1, hold_cnt=0.
- If req == 0, next state=IDLE and outputs stay deasserted.
- Latency: req rising in cycle n gives gnt at cycle n+1 from IDLE.

GRANT:
- hold_cnt increments each cycle.
- End condition: done=1, or req[gnt_id]=0, or hold_cnt==MAX_HOLD-1.
- On end, next edge: state=RELEASE, gnt_valid=0, ptr=gnt_id+1 (wraps 15→0), hold_cnt=0.
- timeout=1 for that one RELEASE cycle only if the end was caused solely by the hold limit.
- If done or a request drop coincides with the hold limit, the release is voluntary: timeout=0.
- Changes on req bits other than req[gnt_id] are ignored during GRANT.
- Grant width: exactly MAX_HOLD cycles when held to the limit; MAX_HOLD=1 gives single-cycle grants.

RELEASE:
- Exactly one cycle with gnt=0 between consecutive grants (bus turnaround).
- Arbitration runs in this cycle using the updated ptr. The next grant appears on the following edge, or state goes to IDLE if req=0.
- The previous holder re-requesting wins only if no other requester is set from ptr onward; it is last in rotation.

gnt_id:
- Retains its last value after release; qualify it with gnt_valid.

Decomposition:
- Shared include header holds state encodings (ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2) and N_REQ=16.
- Rotating priority search is a natural sub-module, rr_pick_16. Inputs: req[15:0], ptr[3:0]. Outputs: any, idx[3:0]. Purely combinational.
- One-hot output generation uses the existing decoder_4_16 with inputs gnt_id[3:2] as the a,b pair, gnt_id[1:0] as the c,d pair, and gnt_valid as enable.

Test Plan:
1. Reset: assert reset with req=16'hFFFF → gnt=0, gnt_valid=0, timeout=0. After release, first grant is id 0 (gnt=16'h0001) one cycle later.
2. Single requester: req=16'h0020 at cycle 0, done=1 at cycle 3 → gnt=16'h0020 cycles 1–3. Cycle 4: gnt=0, timeout=0. Cycle 5: gnt=16'h0020 again (still requesting).
3. Wrap-around fairness: req=16'h8001 steady, done asserted each grant's first cycle, ptr=0 → grant sequence id 0, 15, 0, 15, with one idle cycle between grants.
4. Timeout, MAX_HOLD=4: req=16'h0008 steady, done=0 → gnt=16'h0008 for exactly 4 cycles, then timeout=1 for one cycle with gnt=0, then regrant of id 3.
5. Coincident release and limit, MAX_HOLD=4: done=1 in the 4th grant cycle → RELEASE with timeout=0.
6. Mid-grant reset: reset asserted asynchronously while gnt=16'h0400 → gnt=0 before the next clock edge. After reset release with req=16'h0401 → grant id 0 first (ptr=0).
